// File: rtl/acc_cmd_pkg.sv
// Shared definitions for the accelerator command sequencer: link opcodes,
// sequencer states and job size limits.
package acc_cmd_pkg;

  localparam logic [3:0] OP_START_CAL   = 4'h3;
  localparam logic [3:0] OP_WRITE_VEC   = 4'h4;
  localparam logic [3:0] OP_WRITE_MAT   = 4'h5;
  localparam logic [3:0] OP_READ_RESULT = 4'h6;

  localparam int unsigned JOB_ROWS_MAX = 64;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_VEC_CMD   = 4'd1,
    ST_VEC_DATA  = 4'd2,
    ST_MAT_CMD   = 4'd3,
    ST_MAT_DATA  = 4'd4,
    ST_START     = 4'd5,
    ST_CAL_WAIT  = 4'd6,
    ST_READ_CMD  = 4'd7,
    ST_READ_DATA = 4'd8
  } seq_state_e;

  function automatic logic job_size_ok(input logic [7:0] rows, input logic [7:0] cols,
                                       input int unsigned rows_max);
    return (rows != 8'd0) && (cols != 8'd0) && (32'(rows) <= rows_max);
  endfunction

endpackage

// File: rtl/acc_cmd_sequencer_if.sv
// Word-level command link between the sequencer (master) and the SPI master
// that serialises the words (slave).
interface acc_cmd_sequencer_if #(
  parameter int WORD_SIZE = 16
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 rx_valid;
  logic [WORD_SIZE-1:0] rx_data;

  modport master (output tx_valid, tx_data, input tx_ready, rx_valid, rx_data);
  modport slave  (input tx_valid, tx_data, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/acc_tx_word_reg.sv
// Single-entry valid/ready output register: load a word, hold it until the
// consumer accepts it, then clear.
module acc_tx_word_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/acc_cmd_sequencer.sv
// Host-side initiator for the matrix accelerator link: streams vector and matrix
// operands from the source RAM, starts the calculation and collects the results.
module acc_cmd_sequencer
  import acc_cmd_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int PE_NUMBER     = JOB_ROWS_MAX,
  parameter int SRC_ADDR_SIZE = 15,
  parameter int GUARD_CYCLES  = 8,
  parameter int RX_TIMEOUT    = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [7:0]               job_rows,
  input  logic [7:0]               job_cols,
  output logic [SRC_ADDR_SIZE-1:0] src_addr,
  input  logic [WORD_SIZE-1:0]     src_data,
  acc_cmd_sequencer_if.master      link,
  output logic                     res_valid,
  output logic [WORD_SIZE-1:0]     res_data,
  output logic                     res_last,
  output logic                     done,
  output logic                     err
);

  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(RX_TIMEOUT - 1);

  function automatic logic [WORD_SIZE-1:0] cmd_word(input logic [3:0] op);
    logic [WORD_SIZE-1:0] w;
    w = '0;
    w[WORD_SIZE-1 -: 4] = op;
    return w;
  endfunction

  seq_state_e           state_q, state_d;
  logic [7:0]           rows_q, rows_d, cols_q, cols_d;
  logic [15:0]          mat_total_q, mat_total_d;
  logic [7:0]           vec_cnt_q, vec_cnt_d;
  logic [15:0]          mat_cnt_q, mat_cnt_d;
  logic [7:0]           res_cnt_q, res_cnt_d;
  logic [9:0]           wait_cnt_q, wait_cnt_d;
  logic [TW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                 fetch_q, fetch_d;
  logic                 res_valid_q, res_valid_d;
  logic [WORD_SIZE-1:0] res_data_q, res_data_d;
  logic                 res_last_q, res_last_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 tx_load;
  logic [WORD_SIZE-1:0] tx_load_data;
  logic                 tx_fire, tx_room;
  logic [9:0]           wait_last;

  acc_tx_word_reg #(.WIDTH(WORD_SIZE)) u_tx_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (tx_load_data),
    .ready     (link.tx_ready),
    .valid     (link.tx_valid),
    .data      (link.tx_data)
  );

  assign tx_fire   = link.tx_valid && link.tx_ready;
  // A fetch may be issued when the tx register will be empty by the time its data lands.
  assign tx_room   = !link.tx_valid || link.tx_ready;
  assign wait_last = 10'(rows_q) + 10'(cols_q) + 10'(GUARD_CYCLES - 1);

  always_comb begin
    src_addr = '0;
    if (state_q == ST_VEC_DATA) src_addr = SRC_ADDR_SIZE'(vec_cnt_q);
    else if (state_q == ST_MAT_DATA) src_addr = SRC_ADDR_SIZE'(rows_q) + SRC_ADDR_SIZE'(mat_cnt_q);
  end

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    mat_total_d  = mat_total_q;
    vec_cnt_d    = vec_cnt_q;
    mat_cnt_d    = mat_cnt_q;
    res_cnt_d    = res_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    fetch_d      = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = '0;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_last_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          if (job_size_ok(job_rows, job_cols, PE_NUMBER)) begin
            rows_d       = job_rows;
            cols_d       = job_cols;
            mat_total_d  = 16'(job_rows) * 16'(job_cols);
            tx_load      = 1'b1;
            tx_load_data = cmd_word(OP_WRITE_VEC);
            state_d      = ST_VEC_CMD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_VEC_CMD: if (tx_fire) state_d = ST_VEC_DATA;
      ST_VEC_DATA: begin
        if (fetch_q) begin
          tx_load      = 1'b1;
          tx_load_data = src_data;
        end else if (vec_cnt_q != rows_q) begin
          if (tx_room) begin
            fetch_d   = 1'b1;
            vec_cnt_d = vec_cnt_q + 8'd1;
          end
        end else if (tx_fire) begin
          tx_load      = 1'b1;
          tx_load_data = cmd_word(OP_WRITE_MAT);
          state_d      = ST_MAT_CMD;
        end
      end
      ST_MAT_CMD: if (tx_fire) state_d = ST_MAT_DATA;
      ST_MAT_DATA: begin
        if (fetch_q) begin
          tx_load      = 1'b1;
          tx_load_data = src_data;
        end else if (mat_cnt_q != mat_total_q) begin
          if (tx_room) begin
            fetch_d   = 1'b1;
            mat_cnt_d = mat_cnt_q + 16'd1;
          end
        end else if (tx_fire) begin
          tx_load      = 1'b1;
          tx_load_data = cmd_word(OP_START_CAL);
          state_d      = ST_START;
        end
      end
      ST_START: begin
        if (tx_fire) begin
          wait_cnt_d = '0;
          state_d    = ST_CAL_WAIT;
        end
      end
      ST_CAL_WAIT: begin
        if (wait_cnt_q == wait_last) begin
          tx_load      = 1'b1;
          tx_load_data = cmd_word(OP_READ_RESULT);
          state_d      = ST_READ_CMD;
        end else begin
          wait_cnt_d = wait_cnt_q + 10'd1;
        end
      end
      ST_READ_CMD: begin
        if (tx_fire) begin
          res_cnt_d  = '0;
          idle_cnt_d = '0;
          state_d    = ST_READ_DATA;
        end
      end
      ST_READ_DATA: begin
        if (link.rx_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = link.rx_data;
          res_cnt_d   = res_cnt_q + 8'd1;
          idle_cnt_d  = '0;
          if (res_cnt_q + 8'd1 == cols_q) begin
            res_last_d = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      vec_cnt_d  = '0;
      mat_cnt_d  = '0;
      res_cnt_d  = '0;
      wait_cnt_d = '0;
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      mat_total_q <= '0;
      vec_cnt_q   <= '0;
      mat_cnt_q   <= '0;
      res_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      fetch_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      mat_total_q <= mat_total_d;
      vec_cnt_q   <= vec_cnt_d;
      mat_cnt_q   <= mat_cnt_d;
      res_cnt_q   <= res_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      fetch_q     <= fetch_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign job_ready = (state_q == ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_cmd_sequencer.sv
// Randomized bench for acc_cmd_sequencer: a link slave with random backpressure,
// a source RAM model and a word-list reference model of each job.
module tb_acc_cmd_sequencer;

  localparam int RX_TIMEOUT = 4096;
  localparam int GUARD      = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid, job_ready;
  logic [7:0]  job_rows, job_cols;
  logic [14:0] src_addr;
  logic [15:0] src_data;
  logic        res_valid, res_last, done, err;
  logic [15:0] res_data;

  acc_cmd_sequencer_if #(.WORD_SIZE(16)) link ();

  acc_cmd_sequencer #(.RX_TIMEOUT(RX_TIMEOUT), .GUARD_CYCLES(GUARD)) dut (
    .clk       (clk),
    .reset     (reset),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_rows  (job_rows),
    .job_cols  (job_cols),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .link      (link),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_last  (res_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:32767];
  always @(posedge clk) src_data <= ram[src_addr];

  int checks = 0;
  int errors = 0;

  logic [15:0] tx_q[$], exp_tx[$], rx_words[$], exp_res[$], res_q[$];
  int  done_cnt, err_cnt, last_cnt;
  int  tick_no, last_rx_tick, err_tick;
  int  start_idx, exp_gap, stall_at, stall_cnt, rx_wait, cal_gap;
  bit  in_cal, rx_arm, hold_pending;
  logic [15:0] held_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of the environment, run at the falling edge.
  task automatic tick();
    @(negedge clk);
    tick_no++;
    if (reset) begin
      link.tx_ready = 1'b0;
      link.rx_valid = 1'b0;
      hold_pending  = 1'b0;
      return;
    end
    if (res_valid) res_q.push_back(res_data);
    if (res_last) last_cnt++;
    if (done) done_cnt++;
    if (err) begin err_cnt++; err_tick = tick_no; end
    if (res_last || done) check("last_with_done", 32'(res_last), 32'(done));
    if (hold_pending) begin
      check("tx_hold_valid", 32'(link.tx_valid), 1);
      check("tx_hold_data", 32'(link.tx_data), 32'(held_data));
    end
    if (in_cal) begin
      if (!link.tx_valid) cal_gap++;
      else begin
        check("cal_wait_len", cal_gap, exp_gap);
        in_cal = 1'b0;
      end
    end
    link.rx_valid = 1'b0;
    if (in_cal && cal_gap == 3) begin
      link.rx_valid = 1'b1;
      link.rx_data  = 16'hDEAD;
    end else if (rx_arm && rx_words.size() > 0) begin
      if (rx_wait > 0) rx_wait--;
      else begin
        link.rx_valid = 1'b1;
        link.rx_data  = rx_words.pop_front();
        last_rx_tick  = tick_no;
        rx_wait       = $urandom_range(0, 4);
      end
    end
    if (stall_cnt > 0) begin
      link.tx_ready = 1'b0;
      stall_cnt--;
    end else begin
      link.tx_ready = ($urandom_range(0, 3) != 0);
    end
    if (link.tx_valid && link.tx_ready) begin
      tx_q.push_back(link.tx_data);
      if (tx_q.size() == start_idx + 1) begin in_cal = 1'b1; cal_gap = 0; end
      if (tx_q.size() == exp_tx.size()) begin rx_arm = 1'b1; rx_wait = $urandom_range(0, 3); end
      if (tx_q.size() == stall_at) stall_cnt = 5;
    end
    hold_pending = link.tx_valid && !link.tx_ready;
    held_data    = link.tx_data;
  endtask

  task automatic clear_env();
    tx_q.delete(); res_q.delete();
    done_cnt = 0; err_cnt = 0; last_cnt = 0;
    in_cal = 1'b0; rx_arm = 1'b0; stall_cnt = 0; cal_gap = 0;
    last_rx_tick = 0; err_tick = 0;
  endtask

  task automatic start_job(input int rows, input int cols, input int nrx,
                           input int stall, input bit fixed);
    if (!fixed) for (int i = 0; i < rows + rows * cols; i++) ram[i] = 16'($urandom);
    exp_tx.delete();
    exp_tx.push_back(16'h4000);
    for (int i = 0; i < rows; i++) exp_tx.push_back(ram[i]);
    exp_tx.push_back(16'h5000);
    for (int c = 0; c < cols; c++)
      for (int r = 0; r < rows; r++) exp_tx.push_back(ram[rows + c * rows + r]);
    exp_tx.push_back(16'h3000);
    exp_tx.push_back(16'h6000);
    start_idx = rows + 2 + rows * cols;
    exp_gap   = rows + cols + GUARD;
    rx_words.delete(); exp_res.delete();
    for (int i = 0; i < nrx; i++) begin
      rx_words.push_back(fixed ? ((i == 0) ? 16'h0031 : 16'h0045) : 16'($urandom));
      exp_res.push_back(rx_words[i]);
    end
    clear_env();
    stall_at = stall;
    check("job_ready_idle", 32'(job_ready), 1);
    job_valid = 1'b1; job_rows = 8'(rows); job_cols = 8'(cols);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input int cols, input int bound);
    int n;
    bit ok;
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < bound) begin
      if (n == 6) begin job_valid = 1'b1; job_rows = 8'd0; job_cols = 8'd0; end
      tick();
      job_valid = 1'b0;
      n++;
    end
    if (n >= bound) check("job_bound_expired", 0, 1);
    tick(); tick();
    ok = (exp_res.size() == cols);
    check("tx_count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
      check($sformatf("tx_word%0d", i), 32'(tx_q[i]), 32'(exp_tx[i]));
    check("res_count", res_q.size(), exp_res.size());
    for (int i = 0; i < res_q.size() && i < exp_res.size(); i++)
      check($sformatf("res_word%0d", i), 32'(res_q[i]), 32'(exp_res[i]));
    check("done_pulses", done_cnt, ok ? 1 : 0);
    check("last_pulses", last_cnt, ok ? 1 : 0);
    check("err_pulses", err_cnt, ok ? 0 : 1);
    check("job_ready_after", 32'(job_ready), 1);
    if (!ok) begin
      n = err_tick - last_rx_tick;
      check("rx_timeout_latency", 32'(n >= RX_TIMEOUT && n <= RX_TIMEOUT + 2), 1);
    end
  endtask

  task automatic run_job(input int rows, input int cols, input int nrx,
                         input int stall, input bit fixed);
    start_job(rows, cols, nrx, stall, fixed);
    finish_job(cols, 30000);
  endtask

  task automatic bad_job(input int rows, input int cols);
    clear_env();
    exp_tx.delete(); start_idx = -10; stall_at = -1;
    job_valid = 1'b1; job_rows = 8'(rows); job_cols = 8'(cols);
    tick();
    job_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bad_job_ready", 32'(job_ready), 1);
    end
    check("bad_job_err", err_cnt, 1);
    check("bad_job_tx", tx_q.size(), 0);
  endtask

  initial begin
    int rows, cols, n;
    reset = 1'b1; job_valid = 1'b0; job_rows = '0; job_cols = '0;
    link.tx_ready = 1'b0; link.rx_valid = 1'b0; link.rx_data = '0;
    tick_no = 0; start_idx = -10; stall_at = -1; hold_pending = 1'b0;
    clear_env();
    repeat (3) tick();
    check("rst_job_ready", 32'(job_ready), 1);
    check("rst_tx_valid", 32'(link.tx_valid), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_done_err", {30'd0, done, err}, 0);
    check("rst_src_addr", 32'(src_addr), 0);
    reset = 1'b0;
    tick();

    ram[0] = 16'd1; ram[1] = 16'd2; ram[2] = 16'd10;
    ram[3] = 16'd20; ram[4] = 16'd30; ram[5] = 16'd40;
    run_job(2, 2, 2, 6, 1'b1);
    check("dir_last_word", 32'(res_q.size() == 2 ? res_q[1] : 16'h0), 32'h45);

    bad_job(0, 5);
    bad_job(65, 5);
    bad_job(3, 0);

    for (int j = 0; j < 6; j++) begin
      rows = $urandom_range(1, 12);
      cols = $urandom_range(1, 12);
      run_job(rows, cols, cols, rows + 3 + $urandom_range(0, rows * cols - 1), 1'b0);
    end
    run_job(64, 2, 2, 64 + 3 + 70, 1'b0);
    run_job(1, 255, 255, 10, 1'b0);

    run_job(1, 3, 2, -1, 1'b0);

    start_job(3, 4, 4, -1, 1'b0);
    n = 0;
    while (tx_q.size() < 6 && n < 500) begin tick(); n++; end
    check("reach_mat_data", 32'(tx_q.size() >= 6), 1);
    reset = 1'b1;
    #1;
    check("midrst_tx_valid", 32'(link.tx_valid), 0);
    check("midrst_job_ready", 32'(job_ready), 1);
    check("midrst_done_err", {30'd0, done, err}, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    run_job(3, 4, 4, 9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
